rbcp_responder: RTL and testbench

RBCP_RESPONDER -- requirements
Module: rbcp_responder

---
 rtl/rbcp_responder.sv | 151 +++++++++++++++
 tb/tb_rbcp_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rbcp_responder.sv
// SiTCP RBCP slave: 16-byte register window (ID, ctrl, scratch, pulse, status).
// Define RBCP_RESPONDER_SNAPSHOT_EN to add a free-running cycle counter readable via a snapshot at 0x8-0xB.
module rbcp_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ID_WORD   = 32'h5154_0001
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        rbcp_act,
  input  logic [31:0] rbcp_addr,
  input  logic [7:0]  rbcp_wd,
  input  logic        rbcp_we,
  input  logic        rbcp_re,
  output logic        rbcp_ack,
  output logic [7:0]  rbcp_rd,
  input  logic [31:0] status_in,
  output logic [7:0]  ctrl_reg,
  output logic [7:0]  scratch_reg,
  output logic [7:0]  pulse_out
);

  typedef enum logic [1:0] {IDLE, DECODE, RESP} state_t;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wd;
  } req_t;

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic        ack_q, ack_d;
  logic [7:0]  rd_q, rd_d, ctrl_q, ctrl_d, scr_q, scr_d, pls_q, pls_d;
  logic [7:0]  rd_sel;
  logic        hit;
  logic [3:0]  off;

`ifdef RBCP_RESPONDER_SNAPSHOT_EN
  logic [31:0] cnt_q, snap_q, snap_d;
`endif

  assign off = req_q.addr[3:0];

  // Address decode and read mux on the captured request.
  always_comb begin
    hit    = 1'b0;
    rd_sel = 8'h00;
    if (req_q.addr[31:4] == BASE_ADDR[31:4]) begin
      case (off)
        4'h0: begin hit = 1'b1; rd_sel = ID_WORD[31:24]; end
        4'h1: begin hit = 1'b1; rd_sel = ID_WORD[23:16]; end
        4'h2: begin hit = 1'b1; rd_sel = ID_WORD[15:8];  end
        4'h3: begin hit = 1'b1; rd_sel = ID_WORD[7:0];   end
        4'h4: begin hit = 1'b1; rd_sel = ctrl_q;         end
        4'h5: begin hit = 1'b1; rd_sel = scr_q;          end
        4'h6: begin hit = 1'b1; rd_sel = 8'h00;          end
`ifdef RBCP_RESPONDER_SNAPSHOT_EN
        4'h8: begin hit = 1'b1; rd_sel = cnt_q[31:24];   end
        4'h9: begin hit = 1'b1; rd_sel = snap_q[23:16];  end
        4'hA: begin hit = 1'b1; rd_sel = snap_q[15:8];   end
        4'hB: begin hit = 1'b1; rd_sel = snap_q[7:0];    end
`endif
        4'hC: begin hit = 1'b1; rd_sel = status_in[31:24]; end
        4'hD: begin hit = 1'b1; rd_sel = status_in[23:16]; end
        4'hE: begin hit = 1'b1; rd_sel = status_in[15:8];  end
        4'hF: begin hit = 1'b1; rd_sel = status_in[7:0];   end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    ack_d   = 1'b0;
    rd_d    = 8'h00;
    ctrl_d  = ctrl_q;
    scr_d   = scr_q;
    pls_d   = 8'h00;
`ifdef RBCP_RESPONDER_SNAPSHOT_EN
    snap_d  = snap_q;
`endif
    case (state_q)
      IDLE: if (rbcp_act && (rbcp_we || rbcp_re)) begin
        req_d   = '{we: rbcp_we, addr: rbcp_addr, wd: rbcp_wd};
        state_d = DECODE;
      end
      DECODE: begin
        // Misses and aborted transactions return silently; SiTCP times out.
        if (!rbcp_act || !hit) state_d = IDLE;
        else begin
          state_d = RESP;
          ack_d   = 1'b1;
          if (req_q.we) begin
            case (off)
              4'h4:    ctrl_d = req_q.wd;
              4'h5:    scr_d  = req_q.wd;
              4'h6:    pls_d  = req_q.wd;
              default: ;
            endcase
          end else begin
            rd_d = rd_sel;
`ifdef RBCP_RESPONDER_SNAPSHOT_EN
            if (off == 4'h8) snap_d = cnt_q;
`endif
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      ack_q   <= 1'b0;
      rd_q    <= 8'h00;
      ctrl_q  <= 8'h00;
      scr_q   <= 8'h00;
      pls_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
      scr_q   <= scr_d;
      pls_q   <= pls_d;
    end
  end

`ifdef RBCP_RESPONDER_SNAPSHOT_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q  <= '0;
      snap_q <= '0;
    end else begin
      cnt_q  <= cnt_q + 32'd1;
      snap_q <= snap_d;
    end
  end
`endif

  assign rbcp_ack    = ack_q;
  assign rbcp_rd     = rd_q;
  assign ctrl_reg    = ctrl_q;
  assign scratch_reg = scr_q;
  assign pulse_out   = pls_q;

endmodule

// File: tb/tb_rbcp_responder.sv
// Scoreboard bench for rbcp_responder: expected ack/data/register state queued per strobe.
module tb_rbcp_responder;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        act = 1'b0, we = 1'b0, re = 1'b0;
  logic [31:0] addr = '0, status = 32'hDEAD_BEEF;
  logic [7:0]  wd = '0;
  logic        ack;
  logic [7:0]  rd, ctrl, scr, pls;

  rbcp_responder #(.BASE_ADDR(BASE), .ID_WORD(32'h5154_0001)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .rbcp_act(act), .rbcp_addr(addr),
    .rbcp_wd(wd), .rbcp_we(we), .rbcp_re(re), .rbcp_ack(ack), .rbcp_rd(rd),
    .status_in(status), .ctrl_reg(ctrl), .scratch_reg(scr), .pulse_out(pls)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    bit         ack;
    logic [7:0] rd, pls, ctrl, scr;
  } exp_t;

  exp_t       sbq[$];
  int         cyc = 0, n_vec = 0, n_err = 0;
  logic [7:0] m_ctrl = 8'h00, m_scr = 8'h00;
  logic [31:0] m_cnt;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_cnt <= '0; else m_cnt <= m_cnt + 32'd1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Compare outputs against the queued expectation due this cycle; flag strays otherwise.
  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      exp_t e;
      e = sbq.pop_front();
      chk("ack",   {31'd0, ack}, {31'd0, e.ack});
      chk("rd",    {24'd0, rd},   {24'd0, e.rd});
      chk("pulse", {24'd0, pls},  {24'd0, e.pls});
      chk("ctrl",  {24'd0, ctrl}, {24'd0, e.ctrl});
      chk("scr",   {24'd0, scr},  {24'd0, e.scr});
    end else if (ack || pls != 8'h00 || rd != 8'h00) begin
      chk("stray_ack", {23'd0, ack, pls}, 32'd0);
    end
  end

  function automatic bit is_hit(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 1'b0;
`ifdef RBCP_RESPONDER_SNAPSHOT_EN
    return !(a[3:0] == 4'h7);
`else
    return !(a[3:0] == 4'h7 || (a[3:0] >= 4'h8 && a[3:0] <= 4'hB));
`endif
  endfunction

  // One RBCP access; exp_rd is the expected read byte for hit reads.
  task automatic xact(input logic w, input logic r, input logic [31:0] a,
                      input logic [7:0] d, input logic [7:0] exp_rd, input bit drop);
    exp_t e;
    bit h;
    @(negedge clk);
    act = 1'b1; we = w; re = r; addr = a; wd = d;
    h = is_hit(a) && !drop;
    if (h && w && a[3:0] == 4'h4) m_ctrl = d;
    if (h && w && a[3:0] == 4'h5) m_scr = d;
    e.due  = cyc + 2;
    e.ack  = h;
    e.rd   = (h && !w) ? exp_rd : 8'h00;
    e.pls  = (h && w && a[3:0] == 4'h6) ? d : 8'h00;
    e.ctrl = m_ctrl;
    e.scr  = m_scr;
    sbq.push_back(e);
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    if (drop) act = 1'b0;
    repeat (3) @(negedge clk);
    act = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    logic [31:0] snapv;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [31:0] snapv;
    repeat (3) @(negedge clk);
    chk("rst_ack",  {31'd0, ack}, 32'd0);
    chk("rst_rd",   {24'd0, rd},   32'd0);
    chk("rst_ctrl", {24'd0, ctrl}, 32'd0);
    chk("rst_scr",  {24'd0, scr},  32'd0);
    chk("rst_pls",  {24'd0, pls},  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ID word, big-endian
    xact(0, 1, BASE + 0, 8'h00, 8'h51, 0);
    xact(0, 1, BASE + 1, 8'h00, 8'h54, 0);
    xact(0, 1, BASE + 2, 8'h00, 8'h00, 0);
    xact(0, 1, BASE + 3, 8'h00, 8'h01, 0);
    // scratch RW, ctrl untouched
    xact(1, 0, BASE + 5, 8'hA5, 8'h00, 0);
    xact(0, 1, BASE + 5, 8'h00, 8'hA5, 0);
    xact(0, 1, BASE + 4, 8'h00, 8'h00, 0);
    // misses: out of window, 0x7, 0x8 when snapshot disabled
    xact(0, 1, 32'h0000_0010, 8'h00, 8'h00, 0);
    repeat (16) @(negedge clk);
    xact(0, 1, BASE + 7, 8'h00, 8'h00, 0);
`ifndef RBCP_RESPONDER_SNAPSHOT_EN
    xact(0, 1, BASE + 8, 8'h00, 8'h00, 0);
    repeat (16) @(negedge clk);
`endif
    xact(0, 1, BASE + 0, 8'h00, 8'h51, 0);
    // pulse register
    xact(1, 0, BASE + 6, 8'h81, 8'h00, 0);
    xact(0, 1, BASE + 6, 8'h00, 8'h00, 0);
    // write to RO offset acked and ignored
    xact(1, 0, BASE + 0, 8'hFF, 8'h00, 0);
    xact(0, 1, BASE + 0, 8'h00, 8'h51, 0);
    // status big-endian
    xact(0, 1, BASE + 12, 8'h00, 8'hDE, 0);
    xact(0, 1, BASE + 15, 8'h00, 8'hEF, 0);
    status = 32'h1234_5678;
    xact(0, 1, BASE + 13, 8'h00, 8'h34, 0);
    // we+re together: write wins, rd is zero
    xact(1, 1, BASE + 4, 8'h3C, 8'h00, 0);
    xact(0, 1, BASE + 4, 8'h00, 8'h3C, 0);
    // act drops in DECODE: no ack, no write
    xact(1, 0, BASE + 4, 8'h99, 8'h00, 1);
    chk("drop_ctrl", {24'd0, ctrl}, {24'd0, m_ctrl});

    // strobes during DECODE/RESP ignored
    @(negedge clk);
    act = 1'b1; re = 1'b1; addr = BASE + 5;
    e.due = cyc + 2; e.ack = 1'b1; e.rd = m_scr; e.pls = 8'h00; e.ctrl = m_ctrl; e.scr = m_scr;
    sbq.push_back(e);
    @(negedge clk); re = 1'b0; we = 1'b1; addr = BASE + 4; wd = 8'hFF;
    @(negedge clk); we = 1'b0; re = 1'b1; addr = BASE + 0;
    @(negedge clk); re = 1'b0;
    repeat (3) @(negedge clk); act = 1'b0;
    repeat (2) @(negedge clk);
    chk("ign_ctrl", {24'd0, ctrl}, {24'd0, m_ctrl});

`ifdef RBCP_RESPONDER_SNAPSHOT_EN
    @(negedge clk);
    act = 1'b1; re = 1'b1; addr = BASE + 8;
    snapv = m_cnt + 32'd1;
    e.due = cyc + 2; e.ack = 1'b1; e.rd = snapv[31:24]; e.pls = 8'h00; e.ctrl = m_ctrl; e.scr = m_scr;
    sbq.push_back(e);
    @(negedge clk); re = 1'b0;
    repeat (3) @(negedge clk); act = 1'b0;
    @(negedge clk);
    xact(0, 1, BASE + 9,  8'h00, snapv[23:16], 0);
    xact(0, 1, BASE + 11, 8'h00, snapv[7:0], 0);
`endif

    // reset in DECODE after write to ctrl: aborted, registers cleared
    @(negedge clk);
    act = 1'b1; we = 1'b1; addr = BASE + 4; wd = 8'h77;
    m_ctrl = 8'h00; m_scr = 8'h00;
    e.due = cyc + 2; e.ack = 1'b0; e.rd = 8'h00; e.pls = 8'h00; e.ctrl = 8'h00; e.scr = 8'h00;
    sbq.push_back(e);
    @(negedge clk); we = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ack",  {31'd0, ack}, 32'd0);
    chk("abort_ctrl", {24'd0, ctrl}, 32'd0);
    act = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xact(1, 0, BASE + 4, 8'h77, 8'h00, 0);
    xact(0, 1, BASE + 4, 8'h00, 8'h77, 0);

    repeat (4) @(negedge clk);
    chk("drain", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
